// File: rtl/ldm_stm_seq.sv
// LDM/STM block-transfer sequencer: walks a 16-bit register list lowest-first,
// issues ascending word beats over req/ack, then optionally writes back the base.
// Optional abort input/aborted flag: define LDM_STM_ABORT_EN.
module ldm_stm_seq #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          load,
    input  logic          pre,
    input  logic          up,
    input  logic          wb,
    input  logic [3:0]    rn,
    input  logic [AW-1:0] base,
    input  logic [15:0]   reglist,
    input  logic [AW-1:0] rd2,
    input  logic          mem_ack,
    input  logic [AW-1:0] mem_rdata,
`ifdef LDM_STM_ABORT_EN
    input  logic          abort,
    output logic          aborted,
`endif
    output logic [3:0]    ra2,
    output logic          we3,
    output logic [3:0]    wa3,
    output logic [AW-1:0] wd3,
    output logic          pc_we,
    output logic [AW-1:0] pc_wd,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [AW-1:0] mem_wdata,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_WB   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [AW-1:0] FOUR = AW'(4);

    function automatic logic [4:0] popcount16(input logic [15:0] m);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) begin
            c = c + {4'b0, m[i]};
        end
        return c;
    endfunction

    function automatic logic [3:0] lowest_idx(input logic [15:0] m);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i]) idx = i[3:0];
        end
        return idx;
    endfunction

    state_t        state_q, state_d;
    logic          load_q, load_d;
    logic [3:0]    rn_q, rn_d;
    logic [15:0]   mask_q, mask_d;
    logic          wbgo_q, wbgo_d;
    logic          aborted_q, aborted_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] fbase_q, fbase_d;

    logic [4:0]    cnt;
    logic [AW-1:0] off;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] final_base;
    logic [3:0]    cur;
    logic [15:0]   mask_nxt;
    logic          beat_ok;

    // Start-address and final-base arithmetic for the four addressing modes
    always_comb begin
        cnt       = popcount16(reglist);
        off       = '0;
        off[6:0]  = {cnt, 2'b00};
        case ({pre, up})
            2'b01:   start_addr = base;
            2'b11:   start_addr = base + FOUR;
            2'b00:   start_addr = base - off + FOUR;
            default: start_addr = base - off;
        endcase
        final_base = up ? (base + off) : (base - off);
    end

    assign cur      = lowest_idx(mask_q);
    assign mask_nxt = mask_q & ~(16'h0001 << cur);

    always_comb begin
        state_d   = state_q;
        load_d    = load_q;
        rn_d      = rn_q;
        mask_d    = mask_q;
        wbgo_d    = wbgo_q;
        aborted_d = aborted_q;
        addr_d    = addr_q;
        fbase_d   = fbase_q;
        beat_ok   = 1'b1;

        ra2       = '0;
        we3       = 1'b0;
        wa3       = '0;
        wd3       = '0;
        pc_we     = 1'b0;
        pc_wd     = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load_d    = load;
                    rn_d      = rn;
                    mask_d    = reglist;
                    addr_d    = start_addr;
                    fbase_d   = final_base;
                    wbgo_d    = wb & ~(load & reglist[rn]);
                    aborted_d = 1'b0;
                    state_d   = (reglist == 16'h0000) ? S_DONE : S_XFER;
                end
            end
            S_XFER: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_we   = ~load_q;
                mem_addr = addr_q;
                if (!load_q) begin
                    ra2       = cur;
                    mem_wdata = rd2;
                end
`ifdef LDM_STM_ABORT_EN
                beat_ok = ~abort;
`endif
                if (mem_ack) begin
                    // Load data goes straight to the register file in the ack cycle
                    if (load_q && beat_ok) begin
                        if (cur != 4'd15) begin
                            we3 = 1'b1;
                            wa3 = cur;
                            wd3 = mem_rdata;
                        end else begin
                            pc_we = 1'b1;
                            pc_wd = mem_rdata & ~FOUR + FOUR - AW'(1) & ~AW'(3);
                        end
                    end
                    mask_d = mask_nxt;
                    addr_d = addr_q + FOUR;
                    if (!beat_ok) begin
                        aborted_d = 1'b1;
                        state_d   = S_DONE;
                    end else if (mask_nxt == 16'h0000) begin
                        state_d = wbgo_q ? S_WB : S_DONE;
                    end
                end
            end
            S_WB: begin
                busy = 1'b1;
                if (rn_q == 4'd15) begin
                    pc_we = 1'b1;
                    pc_wd = fbase_q;
                end else begin
                    we3 = 1'b1;
                    wa3 = rn_q;
                    wd3 = fbase_q;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef LDM_STM_ABORT_EN
    assign aborted = aborted_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            load_q    <= 1'b0;
            rn_q      <= '0;
            mask_q    <= '0;
            wbgo_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            load_q    <= load_d;
            rn_q      <= rn_d;
            mask_q    <= mask_d;
            wbgo_q    <= wbgo_d;
            aborted_q <= aborted_d;
        end
    end

    // Address datapath needs no reset: it is only observed outside IDLE
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        fbase_q <= fbase_d;
    end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Randomized bench for ldm_stm_seq against a transaction-level model of the block transfer.
module tb_ldm_stm_seq;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start, load, pre, up, wb;
    logic [3:0]    rn;
    logic [AW-1:0] base;
    logic [15:0]   reglist;
    logic [AW-1:0] rd2;
    logic          mem_ack;
    logic [AW-1:0] mem_rdata;
    logic [3:0]    ra2;
    logic          we3;
    logic [3:0]    wa3;
    logic [AW-1:0] wd3;
    logic          pc_we;
    logic [AW-1:0] pc_wd;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr, mem_wdata;
    logic          busy, done;
`ifdef LDM_STM_ABORT_EN
    logic          abort;
    logic          aborted;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ldm_stm_seq #(.AW(AW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .load(load), .pre(pre),
        .up(up), .wb(wb), .rn(rn), .base(base), .reglist(reglist), .rd2(rd2),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
`ifdef LDM_STM_ABORT_EN
        .abort(abort), .aborted(aborted),
`endif
        .ra2(ra2), .we3(we3), .wa3(wa3), .wd3(wd3), .pc_we(pc_we), .pc_wd(pc_wd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, AW'(busy), '0);
        chk({tag, "_done"}, AW'(done), '0);
        chk({tag, "_req"}, AW'(mem_req), '0);
        chk({tag, "_we3"}, AW'(we3), '0);
        chk({tag, "_pcwe"}, AW'(pc_we), '0);
        chk({tag, "_addr"}, mem_addr, '0);
        chk({tag, "_wd3"}, wd3, '0);
`ifdef LDM_STM_ABORT_EN
        chk({tag, "_aborted"}, AW'(aborted), '0);
`endif
    endtask

    task automatic scramble_cmd();
        start   = 1'($urandom);
        load    = 1'($urandom);
        pre     = 1'($urandom);
        up      = 1'($urandom);
        wb      = 1'($urandom);
        rn      = 4'($urandom);
        base    = $urandom;
        reglist = 16'($urandom);
    endtask

    // One full command: the model lists beats lowest register first at ascending addresses.
    task automatic run_cmd(input logic l, input logic p, input logic u, input logic w,
                           input logic [3:0] r, input logic [AW-1:0] b,
                           input logic [15:0] list, input int dmin, input int dmax);
        int            regs[$];
        int            cnt;
        int            d;
        logic [AW-1:0] lo, fin;
        bit            dowb;
        regs = {};
        for (int i = 0; i < 16; i++) if (list[i]) regs.push_back(i);
        cnt = regs.size();
        if (u) begin
            lo  = p ? b + 32'd4 : b;
            fin = b + AW'(4 * cnt);
        end else begin
            lo  = p ? b - AW'(4 * cnt) : b - AW'(4 * cnt) + 32'd4;
            fin = b - AW'(4 * cnt);
        end
        dowb = w && (cnt != 0) && !(l && list[r]);

        @(negedge clk);
        start = 1'b1; load = l; pre = p; up = u; wb = w; rn = r; base = b; reglist = list;
        mem_ack = 1'b0;
        #1;
        chk("idle_busy", AW'(busy), '0);
        chk("idle_req", AW'(mem_req), '0);

        for (int k = 0; k < cnt; k++) begin
            d = $urandom_range(dmax, dmin);
            for (int c = 0; c <= d; c++) begin
                @(negedge clk);
                scramble_cmd();
                mem_ack   = (c == d);
                mem_rdata = $urandom;
                rd2       = $urandom;
                #1;
                chk("x_busy", AW'(busy), 1);
                chk("x_done", AW'(done), 0);
                chk("x_req", AW'(mem_req), 1);
                chk("x_addr", mem_addr, lo + AW'(4 * k));
                chk("x_memwe", AW'(mem_we), AW'(!l));
                if (!l) begin
                    chk("x_ra2", AW'(ra2), AW'(regs[k]));
                    chk("x_wdata", mem_wdata, rd2);
                end
                if (l && c == d) begin
                    if (regs[k] != 15) begin
                        chk("ld_we3", AW'(we3), 1);
                        chk("ld_wa3", AW'(wa3), AW'(regs[k]));
                        chk("ld_wd3", wd3, mem_rdata);
                        chk("ld_pcwe", AW'(pc_we), 0);
                    end else begin
                        chk("ld_pcwe", AW'(pc_we), 1);
                        chk("ld_pcwd", pc_wd, mem_rdata & ~AW'(3));
                        chk("ld_we3", AW'(we3), 0);
                    end
                end else begin
                    chk("x_we3", AW'(we3), 0);
                    chk("x_pcwe", AW'(pc_we), 0);
                end
            end
        end

        if (dowb) begin
            @(negedge clk);
            scramble_cmd();
            mem_ack = 1'($urandom);
            #1;
            chk("wb_busy", AW'(busy), 1);
            chk("wb_done", AW'(done), 0);
            chk("wb_req", AW'(mem_req), 0);
            if (r != 4'd15) begin
                chk("wb_we3", AW'(we3), 1);
                chk("wb_wa3", AW'(wa3), AW'(r));
                chk("wb_wd3", wd3, fin);
                chk("wb_pcwe", AW'(pc_we), 0);
            end else begin
                chk("wb_pcwe", AW'(pc_we), 1);
                chk("wb_pcwd", pc_wd, fin);
                chk("wb_we3", AW'(we3), 0);
            end
        end

        @(negedge clk);
        scramble_cmd();
        mem_ack = 1'b0;
        #1;
        chk("dn_done", AW'(done), 1);
        chk("dn_busy", AW'(busy), 1);
        chk("dn_req", AW'(mem_req), 0);
        chk("dn_we3", AW'(we3), 0);
        chk("dn_pcwe", AW'(pc_we), 0);

        @(negedge clk);
        start = 1'b0;
        #1;
        chk("post_busy", AW'(busy), 0);
        chk("post_done", AW'(done), 0);
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0; load = 1'b0; pre = 1'b0; up = 1'b0; wb = 1'b0;
        rn = '0; base = '0; reglist = '0; rd2 = '0; mem_ack = 1'b0; mem_rdata = '0;
`ifdef LDM_STM_ABORT_EN
        abort = 1'b0;
`endif
        #1;
        chk_quiet("rst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        run_cmd(1'b1, 1'b0, 1'b1, 1'b1, 4'd4,  32'h100, 16'h000B, 0, 0);
        run_cmd(1'b0, 1'b1, 1'b0, 1'b1, 4'd13, 32'h200, 16'h8003, 0, 2);
        run_cmd(1'b1, 1'b0, 1'b1, 1'b1, 4'd2,  32'h300, 16'h0004, 0, 0);
        run_cmd(1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  32'h400, 16'h8000, 3, 3);
        run_cmd(1'b0, 1'b0, 1'b0, 1'b1, 4'd5,  32'h500, 16'h0000, 0, 0);
        run_cmd(1'b1, 1'b1, 1'b0, 1'b1, 4'd15, 32'h10,  16'h00F0, 0, 1);
        run_cmd(1'b0, 1'b0, 1'b1, 1'b1, 4'd3,  32'hFFFF_FFF8, 16'hFFFF, 0, 0);

        // Reset in the middle of a transfer
        @(negedge clk);
        start = 1'b1; load = 1'b1; pre = 1'b0; up = 1'b1; wb = 1'b1;
        rn = 4'd1; base = 32'h800; reglist = 16'hFFFF; mem_ack = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        reset_n = 1'b0;
        #1;
        chk_quiet("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        mem_ack = 1'b0;
        run_cmd(1'b1, 1'b1, 1'b1, 1'b1, 4'd7, 32'h900, 16'h0421, 0, 2);

        for (int t = 0; t < 40; t++) begin
            logic [15:0] lst;
            lst = 16'($urandom);
            if (t % 5 == 0) lst = 16'h0000;
            else if (t % 3 == 0) lst = lst & 16'($urandom) & 16'($urandom);
            run_cmd(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    4'($urandom), $urandom, lst, 0, $urandom_range(3, 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
